// File: rtl/beep_if.sv
// Buzzer request/status bundle between the vending controller and beep_ctrl.
// The controller drives the request, type and mute; the sequencer reports beep and busy.
interface beep_if;
  logic       beep_req;
  logic [1:0] beep_type;
  logic       mute;
  logic       beep;
  logic       busy;

  modport master (
    output beep_req,
    output beep_type,
    output mute,
    input  beep,
    input  busy
  );

  modport slave (
    input  beep_req,
    input  beep_type,
    input  mute,
    output beep,
    output busy
  );
endinterface

// File: rtl/beep_ctrl.sv
// Buzzer sequencer: turns a one-cycle request into a gated square-wave tone
// following a click / vend / error on-gap pattern.
module beep_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TONE_HZ  = 2_000,
  parameter int UNIT_MS  = 100
) (
  input logic   clk,
  input logic   rst_n,
  beep_if.slave bus
);

  localparam int HALF = CLK_FREQ / (2 * TONE_HZ);
  localparam int UNIT = (CLK_FREQ / 1000) * UNIT_MS;
  localparam int TW   = $clog2(HALF);
  localparam int UW   = $clog2(UNIT);

  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
  localparam logic [UW-1:0] UNIT_M1 = UW'(UNIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  state_t        state, n_state;
  logic [TW-1:0] tone_cnt, n_tone_cnt;
  logic [UW-1:0] unit_cnt, n_unit_cnt;
  logic [2:0]    units_left, n_units_left;
  logic          second, n_second;
  logic          phase, n_phase;
  logic          beep_q, busy_q;

  always_comb begin
    n_state      = state;
    n_tone_cnt   = tone_cnt;
    n_unit_cnt   = unit_cnt;
    n_units_left = units_left;
    n_second     = second;
    n_phase      = phase;

    if (bus.beep_req) begin
      // A new request always restarts, discarding any pattern in flight.
      n_state    = ON;
      n_tone_cnt = '0;
      n_unit_cnt = '0;
      n_phase    = 1'b1;
      unique case (1'b1)
        bus.beep_type == 2'd2: begin
          n_units_left = 3'd5;
          n_second     = 1'b0;
        end
        bus.beep_type == 2'd1: begin
          n_units_left = 3'd1;
          n_second     = 1'b1;
        end
        default: begin
          n_units_left = 3'd1;
          n_second     = 1'b0;
        end
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          n_tone_cnt = '0;
          n_unit_cnt = '0;
          n_phase    = 1'b0;
        end
        ON: begin
          if (tone_cnt == HALF_M1) begin
            n_tone_cnt = '0;
            n_phase    = ~phase;
          end else begin
            n_tone_cnt = tone_cnt + 1'b1;
          end
          if (unit_cnt == UNIT_M1) begin
            n_unit_cnt = '0;
            if (units_left == 3'd1) begin
              n_tone_cnt = '0;
              n_phase    = 1'b0;
              if (second) begin
                n_state      = GAP;
                n_second     = 1'b0;
                n_units_left = 3'd1;
              end else begin
                n_state      = IDLE;
                n_units_left = 3'd0;
              end
            end else begin
              n_units_left = units_left - 3'd1;
            end
          end else begin
            n_unit_cnt = unit_cnt + 1'b1;
          end
        end
        GAP: begin
          if (unit_cnt == UNIT_M1) begin
            n_state    = ON;
            n_unit_cnt = '0;
            n_tone_cnt = '0;
            n_phase    = 1'b1;
          end else begin
            n_unit_cnt = unit_cnt + 1'b1;
          end
        end
        default: n_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tone_cnt   <= '0;
      unit_cnt   <= '0;
      units_left <= '0;
      second     <= 1'b0;
      phase      <= 1'b0;
      beep_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= n_state;
      tone_cnt   <= n_tone_cnt;
      unit_cnt   <= n_unit_cnt;
      units_left <= n_units_left;
      second     <= n_second;
      phase      <= n_phase;
      // Outputs registered from next-state so they line up with the state.
      beep_q     <= n_phase & (n_state == ON) & ~bus.mute;
      busy_q     <= n_state != IDLE;
    end
  end

  assign bus.beep = beep_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_beep_ctrl.sv
// Scoreboard bench for beep_ctrl: each request queues the expected per-cycle
// busy/tone waveform, which is popped and compared every cycle.
module tb_beep_ctrl;

  localparam int HALF = 5;
  localparam int UNIT = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic mute_s;
  logic [1:0] q[$];

  beep_if bif();

  beep_ctrl #(
    .CLK_FREQ(1000),
    .TONE_HZ (100),
    .UNIT_MS (20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_on(input int units);
    for (int i = 0; i < units * UNIT; i++)
      q.push_back({1'b1, ((i / HALF) % 2) == 0});
  endtask

  task automatic push_gap();
    for (int i = 0; i < UNIT; i++)
      q.push_back(2'b10);
  endtask

  task automatic load(input logic [1:0] t);
    q.delete();
    case (t)
      2'd2: push_on(5);
      2'd1: begin
        push_on(1);
        push_gap();
        push_on(1);
      end
      default: push_on(1);
    endcase
  endtask

  // One clock: mute seen at the edge gates the beep of the following cycle.
  task automatic step(input string tag);
    logic [1:0] e;
    @(posedge clk);
    mute_s = bif.mute;
    @(negedge clk);
    e = (q.size() != 0) ? q.pop_front() : 2'b00;
    chk({tag, "_busy"}, 32'(bif.busy), 32'(e[1]));
    chk({tag, "_beep"}, 32'(bif.beep), 32'(e[0] & ~mute_s));
  endtask

  task automatic pulse(input logic [1:0] t, input string tag);
    bif.beep_req  = 1'b1;
    bif.beep_type = t;
    load(t);
    step(tag);
    bif.beep_req  = 1'b0;
    bif.beep_type = 2'd0;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  int busy_len;

  initial begin
    checks        = 0;
    errors        = 0;
    mute_s        = 1'b0;
    bif.beep_req  = 1'b0;
    bif.beep_type = 2'd0;
    bif.mute      = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_beep", 32'(bif.beep), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(5, "idle");

    // Reset in the middle of an error pattern
    pulse(2'd2, "t1");
    run(29, "t1");
    rst_n = 1'b0;
    #1;
    chk("t1_async_busy", 32'(bif.busy), 32'd0);
    chk("t1_async_beep", 32'(bif.beep), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(30, "t1_after");

    // Click
    pulse(2'd0, "t2");
    run(30, "t2");

    // Vend: on, gap, on
    pulse(2'd1, "t3");
    run(70, "t3");

    // Error preempted by click
    pulse(2'd2, "t4");
    run(48, "t4a");
    pulse(2'd0, "t4b");
    run(30, "t4b");

    // Muted error, busy length counted independently
    bif.mute = 1'b1;
    pulse(2'd2, "t5");
    busy_len = 1;
    for (int i = 0; i < 110; i++) begin
      if (i == 38) bif.mute = 1'b0;
      step("t5");
      if (bif.busy) busy_len++;
    end
    chk("t5_busy_len", 32'(busy_len), 32'd100);

    // Type 3 behaves as click
    pulse(2'd3, "t6");
    run(30, "t6");

    // Request held high restarts every cycle
    bif.beep_req  = 1'b1;
    bif.beep_type = 2'd1;
    for (int i = 0; i < 4; i++) begin
      load(2'd1);
      step("held");
    end
    bif.beep_req = 1'b0;
    run(70, "held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
